mawg_freq_meter: RTL

Waveform-measurement receiver that sits on the signal0 output bus of the generator. It counts hysteresis-qualified rising zero crossings of the signed 16-bit sample stream over a programmable gate of valid samples. It reports the crossing count and the sample span between the first and last crossing, from which software derives period and frequency control word (ctrl ≈ 2^32·(crossings−1)/span). Results are handed off through a valid/ready handshake.

---
 rtl/mawg_freq_meter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mawg_freq_meter.sv
// Counts hysteresis-qualified rising zero crossings over a gate of valid samples; reports count and first-to-last span.
// Counter updates are visible one cycle after each sample; the result is held in DONE until result_ready, and start is ignored while busy.
module mawg_freq_meter #(
  parameter int GATE_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [15:0]  sample,
  input  logic                sample_valid,
  input  logic [14:0]         hysteresis,
  input  logic [GATE_W-1:0]   gate_len,
  input  logic                start,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [CNT_W-1:0]    crossings,
  output logic [GATE_W-1:0]   span,
  output logic                overflow
);

  typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_t;
  typedef enum logic [1:0] {SCH_UNKNOWN, SCH_LOW, SCH_HIGH} schmitt_t;

  typedef struct packed {
    logic [CNT_W-1:0]  crossings;
    logic [GATE_W-1:0] span;
    logic              overflow;
  } result_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_W'(1);

  state_t             state;
  schmitt_t           sch;
  schmitt_t           sch_next;
  result_t            res;
  logic [14:0]        h_q;
  logic [GATE_W-1:0]  gate_q;
  logic [GATE_W-1:0]  idx;
  logic [GATE_W-1:0]  first_idx;
  logic signed [16:0] s_ext;
  logic signed [16:0] h_pos;
  logic signed [16:0] h_neg;
  logic               is_high;
  logic               is_low;
  logic               rise;

  assign s_ext   = {sample[15], sample};
  assign h_pos   = {2'b00, h_q};
  assign h_neg   = -h_pos;
  assign is_high = (s_ext >= h_pos);
  assign is_low  = (s_ext <= h_neg);

  // HIGH wins when both thresholds are met (H = 0, sample = 0)
  always_comb begin
    sch_next = sch;
    if (is_high)
      sch_next = SCH_HIGH;
    else if (is_low)
      sch_next = SCH_LOW;
  end

  assign rise = (sch == SCH_LOW) && (sch_next == SCH_HIGH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      sch          <= SCH_UNKNOWN;
      res          <= '0;
      h_q          <= '0;
      gate_q       <= '0;
      idx          <= '0;
      first_idx    <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            h_q       <= hysteresis;
            gate_q    <= gate_len;
            idx       <= '0;
            first_idx <= '0;
            res       <= '0;
            sch       <= SCH_UNKNOWN;
            busy      <= 1'b1;
            if (gate_len == '0) begin
              state        <= DONE;
              result_valid <= 1'b1;
            end else begin
              state <= MEASURE;
            end
          end
        end
        MEASURE: begin
          if (sample_valid) begin
            sch <= sch_next;
            idx <= idx + GATE_W'(1);
            if (rise) begin
              // span tracks last - first; last keeps moving after saturation
              if (res.crossings == '0)
                first_idx <= idx;
              else
                res.span <= idx - first_idx;
              if (res.crossings != CNT_MAX) begin
                res.crossings <= res.crossings + CNT_W'(1);
                if (res.crossings == CNT_PRE)
                  res.overflow <= 1'b1;
              end
            end
            if (idx == gate_q - GATE_W'(1)) begin
              state        <= DONE;
              result_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
          end
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

  assign crossings = res.crossings;
  assign span      = res.span;
  assign overflow  = res.overflow;

endmodule
